switch_debouncer: RTL and testbench

Upstream conditioning stage for the lab1 board inputs. It takes the asynchronous, bouncing DIP-switch lines and produces clean, clock-synchronous switch levels that feed the LED logic's `s` input. Each bit passes through a two-flop synchronizer and then a per-bit debounce counter. The block also emits one-cycle rise/fall strobes for downstream event logic. It runs in the HSOSC domain (24 MHz nominal).

---
 rtl/lab1_pkg.sv | 13 +
 rtl/debounce_bit.sv | 102 ++++++++++
 rtl/switch_debouncer.sv | 49 ++++
 tb/tb_switch_debouncer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab1_pkg.sv
// Board-wide constants for lab1 plus the per-bit debounce state type.
package lab1_pkg;

    localparam int unsigned CLK_HZ          = 24_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One switch line: two-flop synchronizer, persistence counter and registered
// rise/fall strobes. event_d is the pre-register strobe so the parent can align `changed`.
module debounce_bit
    import lab1_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic event_d
);

    localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mismatch;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clean_d  = clean_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        sync1_d  = raw;
        sync2_d  = sync1_q;
        mismatch = (sync2_q != clean_q);

        unique case (state_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (mismatch) begin
                    // With CNT_MAX == 1 the idle count already equals the last value.
                    if (cnt_q == CNT_LAST) begin
                        clean_d = sync2_q;
                        rise_d  = sync2_q;
                        fall_d  = ~sync2_q;
                    end else begin
                        state_d = DB_PENDING;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            DB_PENDING: begin
                if (!mismatch) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                    clean_d = sync2_q;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean   = clean_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign event_d = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous switch lines and flags any accepted level change
// with a single registered `changed` pulse aligned to the per-bit strobes.
module switch_debouncer
    import lab1_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned CNT_MAX = DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    logic [WIDTH-1:0] event_d;
    logic             changed_q, changed_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .CNT_MAX (CNT_MAX)
        ) u_bit (
            .clk     (clk),
            .reset   (reset),
            .raw     (sw_raw[i]),
            .clean   (sw_clean[i]),
            .rise    (sw_rise[i]),
            .fall    (sw_fall[i]),
            .event_d (event_d[i])
        );
    end

    always_comb begin
        changed_d = |event_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign changed = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer (WIDTH=4, CNT_MAX=8): directed timing
// scenarios plus random bursts, all compared against a sliding-window reference model.
module tb_switch_debouncer;

    localparam int CM = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw_raw = 4'h0;
    logic [3:0] sw_clean, sw_rise, sw_fall;
    logic       changed;

    int checks = 0;
    int errors = 0;

    switch_debouncer #(
        .WIDTH   (4),
        .CNT_MAX (CM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Reference model: a bit's clean level flips once the synchronized value has
    // differed from it on each of the last CM edges since reset.
    logic [3:0] m_clean = 4'h0, m_rise = 4'h0, m_fall = 4'h0;
    logic       m_chg = 1'b0;
    logic [3:0] cap_q[$];
    logic [3:0] cmp_q[$];

    always @(posedge clk) begin
        logic [3:0] seen;
        logic       all_diff;
        if (!reset) begin
            cap_q.delete();
            cmp_q.delete();
            m_clean = 4'h0;
            m_rise  = 4'h0;
            m_fall  = 4'h0;
            m_chg   = 1'b0;
        end else begin
            seen = (cap_q.size() == 2) ? cap_q[0] : 4'h0;
            cap_q.push_back(sw_raw);
            if (cap_q.size() > 2) void'(cap_q.pop_front());
            cmp_q.push_back(seen);
            if (cmp_q.size() > CM) void'(cmp_q.pop_front());
            m_rise = 4'h0;
            m_fall = 4'h0;
            for (int b = 0; b < 4; b++) begin
                all_diff = (cmp_q.size() == CM);
                foreach (cmp_q[j]) if (cmp_q[j][b] == m_clean[b]) all_diff = 1'b0;
                if (all_diff) begin
                    if (m_clean[b]) m_fall[b] = 1'b1;
                    else            m_rise[b] = 1'b1;
                    m_clean[b] = ~m_clean[b];
                end
            end
            m_chg = |(m_rise | m_fall);
        end
    end

    function automatic logic [12:0] obs();
        return {sw_clean, sw_rise, sw_fall, changed};
    endfunction

    function automatic logic [12:0] mdl();
        return {m_clean, m_rise, m_fall, m_chg};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [12:0] exp;
        sw_raw = 4'hF;
        reset  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs() !== 13'h0) begin
                errors++;
                $display("FAIL reset_hold: cycle %0d got %h want %h", k, obs(), 13'h0);
            end
        end
        reset = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            exp = {(k >= 9) ? 4'hF : 4'h0, (k == 9) ? 4'hF : 4'h0, 4'h0, k == 9};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL reset_release: edge %0d got %h want %h", k, obs(), exp);
            end
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL reset_model: edge %0d got %h want %h", k, obs(), mdl());
            end
        end
    endtask

    task automatic test_glitch();
        sw_raw = 4'h0;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL glitch_settle: edge %0d got %h want %h", k, obs(), mdl());
            end
        end
        sw_raw = 4'b0001;
        for (int k = 0; k < 19; k++) begin
            if (k == 7) sw_raw = 4'h0;
            tick();
            checks++;
            if (obs() !== 13'h0) begin
                errors++;
                $display("FAIL glitch_reject: edge %0d got %h want %h", k, obs(), 13'h0);
            end
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL glitch_model: edge %0d got %h want %h", k, obs(), mdl());
            end
        end
    endtask

    task automatic test_threshold();
        logic [12:0] exp;
        for (int phase = 0; phase < 2; phase++) begin
            sw_raw = (phase == 0) ? 4'b0100 : 4'b0000;
            for (int k = 0; k <= 11; k++) begin
                tick();
                if (phase == 0)
                    exp = {(k >= 9) ? 4'b0100 : 4'b0000, (k == 9) ? 4'b0100 : 4'b0000, 4'b0000, k == 9};
                else
                    exp = {(k >= 9) ? 4'b0000 : 4'b0100, 4'b0000, (k == 9) ? 4'b0100 : 4'b0000, k == 9};
                checks++;
                if (obs() !== exp) begin
                    errors++;
                    $display("FAIL threshold_%0d: edge %0d got %h want %h", phase, k, obs(), exp);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int          rises = 0;
        logic [12:0] exp;
        for (int c = 0; c < 20; c++) begin
            sw_raw[1] = ((c % 4) < 2);
            tick();
            rises += int'(sw_rise[1]);
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL bounce_model: cycle %0d got %h want %h", c, obs(), mdl());
            end
        end
        sw_raw[1] = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            tick();
            rises += int'(sw_rise[1]);
            exp = {(k >= 9) ? 4'b0010 : 4'b0000, (k == 9) ? 4'b0010 : 4'b0000, 4'b0000, k == 9};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL bounce_hold: edge %0d got %h want %h", k, obs(), exp);
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d want %0d", rises, 1);
        end
    endtask

    task automatic test_simultaneous();
        int          pulses = 0;
        logic [12:0] exp;
        sw_raw = 4'b1001;
        for (int k = 0; k <= 11; k++) begin
            tick();
            pulses += int'(changed);
            exp = {(k >= 9) ? 4'b1001 : 4'b0010, (k == 9) ? 4'b1001 : 4'b0000,
                   (k == 9) ? 4'b0010 : 4'b0000, k == 9};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL simultaneous: edge %0d got %h want %h", k, obs(), exp);
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL simultaneous_changed: got %0d want %0d", pulses, 1);
        end
    endtask

    task automatic test_reset_midcount();
        logic [12:0] exp;
        sw_raw = 4'b1000;
        for (int k = 0; k < 12; k++) tick();
        checks++;
        if (obs() !== mdl() || sw_clean !== 4'b1000) begin
            errors++;
            $display("FAIL midcount_setup: got %h want clean %h", obs(), 4'b1000);
        end
        sw_raw = 4'b1001;
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (obs() !== 13'h0) begin
            errors++;
            $display("FAIL midcount_reset: got %h want %h", obs(), 13'h0);
        end
        reset = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            tick();
            exp = {(k >= 9) ? 4'b1001 : 4'b0000, (k == 9) ? 4'b1001 : 4'b0000, 4'b0000, k == 9};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL midcount_release: edge %0d got %h want %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_random();
        int left = 0;
        for (int c = 0; c < 600; c++) begin
            if (left == 0) begin
                sw_raw = 4'($urandom);
                left   = int'($urandom_range(1, 14));
            end
            left--;
            reset = ($urandom_range(0, 59) != 0);
            tick();
            checks++;
            if (obs() !== mdl()) begin
                errors++;
                $display("FAIL random: cycle %0d raw %h got %h want %h", c, sw_raw, obs(), mdl());
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_threshold();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
